// File: rtl/pcie_axi_wr_if.sv
// AXI write-channel bundle (AW, W, B) between a PCIe-side master and the
// SRAM write slave.
//   slave  modport : used by pcie_axi_wr_to_sram (accepts AW/W, drives B)
//   master modport : used by the requester (drives AW/W, accepts B)
interface pcie_axi_wr_if;
  logic         axi_awvalid;
  logic [63:0]  axi_awaddr;
  logic [11:0]  axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_awready;
  logic         axi_wvalid;
  logic [255:0] axi_wdata;
  logic [31:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wready;
  logic         axi_bvalid;
  logic [1:0]   axi_bresp;
  logic         axi_bready;

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    input  axi_bready,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp
  );

  modport master (
    output axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    output axi_bready,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp
  );
endinterface

// File: rtl/pcie_axi_wr_to_sram.sv
// AXI write slave committing 256-bit write beats into a 1024-entry SRAM.
// Each accepted burst is written beat by beat through a registered SRAM
// write port; burst length comes only from awlen, and a wlast that does
// not line up with it turns the response into SLVERR.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   axi         : AW/W/B channels (pcie_axi_wr_if.slave)
//   sram_wen    : one-cycle write strobe
//   sram_waddr  : 10-bit SRAM word address
//   sram_wdata  : 256-bit write data
//   sram_wstrb  : 32-bit byte enables
module pcie_axi_wr_to_sram (
  input  logic                 clk,
  input  logic                 rst,
  pcie_axi_wr_if.slave         axi,
  output logic                 sram_wen,
  output logic [9:0]           sram_waddr,
  output logic [255:0]         sram_wdata,
  output logic [31:0]          sram_wstrb
);

  localparam int DATA_W  = 256;
  localparam int STRB_W  = DATA_W / 8;
  localparam int SRAM_AW = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_W_DATA = 2'd1;
  localparam logic [1:0] ST_W_RESP = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]         state;
  logic [SRAM_AW-1:0] addr_cnt;
  logic               burst_fixed;
  logic [12:0]        beats_total;
  logic [12:0]        beat_cnt;
  logic               err;

  logic               w_hs;
  logic               exp_last;
  logic               wlast_bad;

  // Upper address bits and awsize carry no meaning for this slave.
  logic               unused_sink;
  assign unused_sink = ^{axi.axi_awaddr[63:SRAM_AW], axi.axi_awsize};

  // INCR wraps naturally at the SRAM boundary; FIXED keeps the word index.
  function automatic logic [SRAM_AW-1:0] next_addr(input logic [SRAM_AW-1:0] a,
                                                   input logic fixed);
    return fixed ? a : a + 1'b1;
  endfunction

  function automatic logic [1:0] resp_code(input logic bad);
    return bad ? RESP_SLVERR : RESP_OKAY;
  endfunction

  assign w_hs      = axi.axi_wvalid && axi.axi_wready;
  assign exp_last  = (beat_cnt == beats_total - 13'd1);
  assign wlast_bad = (axi.axi_wlast != exp_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      addr_cnt        <= '0;
      burst_fixed     <= 1'b0;
      beats_total     <= '0;
      beat_cnt        <= '0;
      err             <= 1'b0;
      axi.axi_awready <= 1'b0;
      axi.axi_wready  <= 1'b0;
      axi.axi_bvalid  <= 1'b0;
      axi.axi_bresp   <= RESP_OKAY;
      sram_wen        <= 1'b0;
      sram_waddr      <= '0;
      sram_wdata      <= '0;
      sram_wstrb      <= '0;
    end else begin
      sram_wen <= 1'b0;
      case (state)
        ST_IDLE: begin
          axi.axi_awready <= 1'b1;
          if (axi.axi_awvalid && axi.axi_awready) begin
            addr_cnt        <= axi.axi_awaddr[SRAM_AW-1:0];
            burst_fixed     <= (axi.axi_awburst == BURST_FIXED);
            beats_total     <= {1'b0, axi.axi_awlen} + 13'd1;
            beat_cnt        <= '0;
            err             <= 1'b0;
            axi.axi_awready <= 1'b0;
            axi.axi_wready  <= 1'b1;
            state           <= ST_W_DATA;
          end
        end

        // Beat accepted here is presented to the SRAM on the next cycle.
        ST_W_DATA: begin
          if (w_hs) begin
            sram_wen   <= 1'b1;
            sram_waddr <= addr_cnt;
            sram_wdata <= axi.axi_wdata;
            sram_wstrb <= axi.axi_wstrb;
            addr_cnt   <= next_addr(addr_cnt, burst_fixed);
            if (!exp_last) begin
              beat_cnt <= beat_cnt + 13'd1;
              err      <= err | wlast_bad;
            end else begin
              // Response rises alongside the final SRAM strobe.
              axi.axi_wready <= 1'b0;
              axi.axi_bvalid <= 1'b1;
              axi.axi_bresp  <= resp_code(err | wlast_bad);
              state          <= ST_W_RESP;
            end
          end
        end

        ST_W_RESP: begin
          if (axi.axi_bvalid && axi.axi_bready) begin
            axi.axi_bvalid  <= 1'b0;
            axi.axi_bresp   <= RESP_OKAY;
            axi.axi_awready <= 1'b1;
            state           <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_axi_wr_to_sram.sv
// Directed bench for pcie_axi_wr_to_sram: a table of write beats with
// hand-computed SRAM/response expectations, plus hand-written sequences
// for back-pressure and reset in the middle of a burst.
module tb_pcie_axi_wr_to_sram;

  logic         clk;
  logic         rst;
  logic         sram_wen;
  logic [9:0]   sram_waddr;
  logic [255:0] sram_wdata;
  logic [31:0]  sram_wstrb;

  pcie_axi_wr_if bus ();

  pcie_axi_wr_to_sram dut (
    .clk        (clk),
    .rst        (rst),
    .axi        (bus.slave),
    .sram_wen   (sram_wen),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .sram_wstrb (sram_wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         new_burst;
    logic [63:0]  awaddr;
    logic [11:0]  awlen;
    logic [1:0]   awburst;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast;
    logic [9:0]   exp_waddr;
    logic         exp_end;
    logic [1:0]   exp_bresp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] dat(input int i);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(i);
    return {8{w}};
  endfunction

  task automatic add(input logic nb, input logic [63:0] a, input logic [11:0] len,
                     input logic [1:0] burst, input logic [255:0] d, input logic [31:0] s,
                     input logic last, input logic [9:0] ea, input logic ee,
                     input logic [1:0] eb);
    vec_t v;
    v.new_burst = nb;  v.awaddr = a;    v.awlen = len;  v.awburst = burst;
    v.wdata = d;       v.wstrb = s;     v.wlast = last; v.exp_waddr = ea;
    v.exp_end = ee;    v.exp_bresp = eb;
    vecs.push_back(v);
  endtask

  task automatic aw_send(input logic [63:0] a, input logic [11:0] len, input logic [1:0] burst);
    int n;
    n = 0;
    while (bus.axi_awready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("aw_ready_wait", 256'(bus.axi_awready), 256'(1));
    bus.axi_awvalid = 1'b1;
    bus.axi_awaddr  = a;
    bus.axi_awlen   = len;
    bus.axi_awburst = burst;
    bus.axi_awsize  = 3'd5;
    @(posedge clk); #1;
    bus.axi_awvalid = 1'b0;
    chk("aw_accept_awready", 256'(bus.axi_awready), 256'(0));
    chk("aw_accept_wready", 256'(bus.axi_wready), 256'(1));
  endtask

  task automatic b_accept();
    bus.axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.axi_bready = 1'b0;
    chk("b_done_bvalid", 256'(bus.axi_bvalid), 256'(0));
    chk("b_done_bresp", 256'(bus.axi_bresp), 256'(0));
    chk("b_done_awready", 256'(bus.axi_awready), 256'(1));
  endtask

  task automatic beat(input logic [255:0] d, input logic [31:0] s, input logic last);
    bus.axi_wvalid = 1'b1;
    bus.axi_wdata  = d;
    bus.axi_wstrb  = s;
    bus.axi_wlast  = last;
    @(posedge clk); #1;
    bus.axi_wvalid = 1'b0;
    bus.axi_wlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.axi_awvalid = 1'b0; bus.axi_awaddr = '0; bus.axi_awlen = '0;
    bus.axi_awsize = '0;    bus.axi_awburst = '0;
    bus.axi_wvalid = 1'b0;  bus.axi_wdata = '0;  bus.axi_wstrb = '0;
    bus.axi_wlast = 1'b0;   bus.axi_bready = 1'b0;

    // Single beat
    add(1, 64'h0000_0005, 12'd0, 2'b01, {32{8'hA5}}, 32'hFFFF_FFFF, 1, 10'd5, 1, 2'b00);
    // INCR wrap at the top of the SRAM; upper address bits ignored
    add(1, 64'hDEAD_0000_0000_07FE, 12'd3, 2'b01, dat(0), 32'hFFFF_FFFF, 0, 10'd1022, 0, 2'b00);
    add(0, 64'h0, 12'd0, 2'b00, dat(1), 32'hFFFF_FFFF, 0, 10'd1023, 0, 2'b00);
    add(0, 64'h0, 12'd0, 2'b00, dat(2), 32'hFFFF_FFFF, 0, 10'd0,    0, 2'b00);
    add(0, 64'h0, 12'd0, 2'b00, dat(3), 32'hFFFF_FFFF, 1, 10'd1,    1, 2'b00);
    // FIXED burst with varied strobes
    add(1, 64'h10, 12'd2, 2'b00, dat(16), 32'h0000_000F, 0, 10'd16, 0, 2'b00);
    add(0, 64'h0,  12'd0, 2'b00, dat(17), 32'h0000_0000, 0, 10'd16, 0, 2'b00);
    add(0, 64'h0,  12'd0, 2'b00, dat(18), 32'hFFFF_FFFF, 1, 10'd16, 1, 2'b00);
    // Early wlast on beat 1, missing on the real last beat
    add(1, 64'h20, 12'd3, 2'b01, dat(32), 32'h1234_5678, 0, 10'd32, 0, 2'b10);
    add(0, 64'h0,  12'd0, 2'b00, dat(33), 32'h8765_4321, 1, 10'd33, 0, 2'b10);
    add(0, 64'h0,  12'd0, 2'b00, dat(34), 32'h0F0F_0F0F, 0, 10'd34, 0, 2'b10);
    add(0, 64'h0,  12'd0, 2'b00, dat(35), 32'hF0F0_F0F0, 0, 10'd35, 1, 2'b10);
    // Clean burst afterwards; WRAP encoding behaves as INCR
    add(1, 64'h40, 12'd1, 2'b10, dat(64), 32'hFFFF_FFFF, 0, 10'd64, 0, 2'b00);
    add(0, 64'h0,  12'd0, 2'b00, dat(65), 32'hFFFF_FFFF, 1, 10'd65, 1, 2'b00);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 256'(bus.axi_awready), 256'(0));
    chk("rst_wready", 256'(bus.axi_wready), 256'(0));
    chk("rst_bvalid", 256'(bus.axi_bvalid), 256'(0));
    chk("rst_bresp", 256'(bus.axi_bresp), 256'(0));
    chk("rst_wen", 256'(sram_wen), 256'(0));
    chk("rst_waddr", 256'(sram_waddr), 256'(0));
    chk("rst_wdata", sram_wdata, 256'(0));
    chk("rst_wstrb", 256'(sram_wstrb), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_awready", 256'(bus.axi_awready), 256'(1));

    // Table-driven bursts, beats back to back within a burst
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.new_burst) aw_send(v.awaddr, v.awlen, v.awburst);
      beat(v.wdata, v.wstrb, v.wlast);
      chk($sformatf("v%0d_wen", i), 256'(sram_wen), 256'(1));
      chk($sformatf("v%0d_waddr", i), 256'(sram_waddr), 256'(v.exp_waddr));
      chk($sformatf("v%0d_wdata", i), sram_wdata, v.wdata);
      chk($sformatf("v%0d_wstrb", i), 256'(sram_wstrb), 256'(v.wstrb));
      chk($sformatf("v%0d_bvalid", i), 256'(bus.axi_bvalid), 256'(v.exp_end));
      chk($sformatf("v%0d_wready", i), 256'(bus.axi_wready), 256'(!v.exp_end));
      if (v.exp_end) begin
        chk($sformatf("v%0d_bresp", i), 256'(bus.axi_bresp), 256'(v.exp_bresp));
        chk($sformatf("v%0d_awready", i), 256'(bus.axi_awready), 256'(0));
        b_accept();
      end
    end

    // Back-pressure: gaps in wvalid, stray awvalid, bready held low
    aw_send(64'h100, 12'd3, 2'b01);
    for (int k = 0; k < 4; k++) begin
      beat(dat(256 + k), 32'hFFFF_FFFF, 1'b0);
      chk($sformatf("bp%0d_wen", k), 256'(sram_wen), 256'(1));
      chk($sformatf("bp%0d_waddr", k), 256'(sram_waddr), 256'(10'd256 + 10'(k)));
      if (k < 3) begin
        bus.axi_awvalid = 1'b1;
        @(posedge clk); #1;
        bus.axi_awvalid = 1'b0;
        chk($sformatf("bp%0d_gap_wen", k), 256'(sram_wen), 256'(0));
        chk($sformatf("bp%0d_gap_waddr", k), 256'(sram_waddr), 256'(10'd256 + 10'(k)));
        chk($sformatf("bp%0d_gap_awready", k), 256'(bus.axi_awready), 256'(0));
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_bvalid", k), 256'(bus.axi_bvalid), 256'(1));
      chk($sformatf("bp_hold%0d_bresp", k), 256'(bus.axi_bresp), 256'(2'b10));
      chk($sformatf("bp_hold%0d_awready", k), 256'(bus.axi_awready), 256'(0));
      @(posedge clk); #1;
    end
    chk("bp_hold_wen", 256'(sram_wen), 256'(0));
    b_accept();

    // Reset in the middle of an 8-beat burst
    aw_send(64'h200, 12'd7, 2'b01);
    beat(dat(512), 32'hFFFF_FFFF, 1'b0);
    chk("mr_b0_waddr", 256'(sram_waddr), 256'(10'd512));
    beat(dat(513), 32'hFFFF_FFFF, 1'b0);
    chk("mr_b1_waddr", 256'(sram_waddr), 256'(10'd513));
    bus.axi_wvalid = 1'b1;
    bus.axi_wdata  = dat(514);
    rst = 1'b1;
    #1;
    chk("mr_awready", 256'(bus.axi_awready), 256'(0));
    chk("mr_wready", 256'(bus.axi_wready), 256'(0));
    chk("mr_bvalid", 256'(bus.axi_bvalid), 256'(0));
    chk("mr_wen", 256'(sram_wen), 256'(0));
    chk("mr_waddr", 256'(sram_waddr), 256'(0));
    chk("mr_wdata", sram_wdata, 256'(0));
    chk("mr_wstrb", 256'(sram_wstrb), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("mr_held_wen", 256'(sram_wen), 256'(0));
    bus.axi_wvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mr_rel_awready_pre", 256'(bus.axi_awready), 256'(0));
    @(posedge clk); #1;
    chk("mr_rel_awready", 256'(bus.axi_awready), 256'(1));
    chk("mr_rel_bvalid", 256'(bus.axi_bvalid), 256'(0));
    chk("mr_rel_wen", 256'(sram_wen), 256'(0));
    aw_send(64'h3FF, 12'd0, 2'b01);
    beat(dat(1023), 32'hAAAA_5555, 1'b1);
    chk("mr_new_wen", 256'(sram_wen), 256'(1));
    chk("mr_new_waddr", 256'(sram_waddr), 256'(10'd1023));
    chk("mr_new_wdata", sram_wdata, dat(1023));
    chk("mr_new_wstrb", 256'(sram_wstrb), 256'(32'hAAAA_5555));
    chk("mr_new_bvalid", 256'(bus.axi_bvalid), 256'(1));
    chk("mr_new_bresp", 256'(bus.axi_bresp), 256'(0));
    b_accept();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_axi_wr_to_sram.md
# pcie_axi_wr_to_sram

AXI write slave that accepts PCIe-side write bursts on the AW/W/B channels and commits each 256-bit beat into the local 1024-entry SRAM through a registered write port. It is the write-direction companion of the SRAM read slave. Both blocks sit on the same SRAM and share the same 10-bit word-address convention.

## Interface
Parameters: none. Widths are fixed at 64-bit address, 256-bit data and 10-bit SRAM address.

- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  reset, asynchronous and active-high
- axi_awvalid  in  1  write address valid
- axi_awaddr  in  64  byte-agnostic address; bits [9:0] are the SRAM word index and bits [63:10] are ignored
- axi_awlen  in  12  beats minus 1 (1..4096 beats)
- axi_awsize  in  3  ignored; every beat is 256 bits
- axi_awburst  in  2  2'b00 = FIXED (address held); any other value = INCR
- axi_awready  out  1  address accept
- axi_wvalid  in  1  write data valid
- axi_wdata  in  256  beat data
- axi_wstrb  in  32  byte enables
- axi_wlast  in  1  master's last-beat marker
- axi_wready  out  1  data accept
- axi_bvalid  out  1  write response valid
- axi_bresp  out  2  2'b00 = OKAY, 2'b10 = SLVERR
- axi_bready  in  1  response accept
- sram_wen  out  1  one-cycle write strobe
- sram_waddr  out  10  SRAM word address
- sram_wdata  out  256  SRAM write data
- sram_wstrb  out  32  SRAM byte enables

## Operation
- **States:** IDLE, W_DATA, W_RESP.
- **Reset:** all outputs go to 0 (awready, wready, bvalid, bresp=00, sram_wen, sram_waddr, sram_wdata, sram_wstrb). Internal registers clear and the state returns to IDLE. Asserting reset mid-burst discards the burst: no further SRAM writes and no B response.
- **IDLE:**
  - axi_awready is driven to 1 (registered).
  - On awvalid && awready: capture awaddr[9:0] into addr_cnt and awburst; set beats_total = awlen+1 (13-bit, no overflow); clear beat_cnt and err.
  - Same edge: awready←0, wready←1, state←W_DATA.
- **W_DATA**, on each wvalid && wready:
  - sram_wen←1, sram_waddr←addr_cnt, sram_wdata←wdata, sram_wstrb←wstrb. Strobes pass through unchanged, including all-zero.
  - addr_cnt increments modulo 1024 for INCR (1023 wraps to 0) and is held for FIXED.
  - Expected last = (beat_cnt == beats_total-1). If wlast ≠ expected last, set err (sticky for the burst).
  - Not the expected last beat: beat_cnt←beat_cnt+1 and stay in W_DATA.
  - Expected last beat: wready←0, bvalid←1, bresp←(err or mismatch on this beat) ? 2'b10 : 2'b00, state←W_RESP.
- **Burst length:** set only by awlen. An early wlast does not end the burst; it only flags SLVERR.
- **W_RESP:** hold bvalid and bresp stable until bready. On bvalid && bready: bvalid←0, bresp←00, state←IDLE, awready←1 on the same edge.
- **Address-channel back-pressure:** awvalid outside IDLE is not accepted because awready is 0.
- **Default each cycle:** sram_wen←0. sram_waddr, sram_wdata and sram_wstrb hold their last values.

## Timing
- **Reset release:** awready rises on the first clock edge after rst deasserts.
- **AW handshake at edge T:** wready=1 from T. The earliest W handshake is edge T+1.
- **SRAM write latency:** a W handshake at edge T puts sram_wen=1 with address, data and strobe valid during cycle T..T+1. The SRAM captures them at T+1.
- **Throughput:** back-to-back wvalid gives one SRAM write per cycle with no bubbles. Gaps in wvalid produce gaps in sram_wen.
- **Response:** for a final W handshake at edge T, bvalid=1 during the same cycle as the final sram_wen.
- **B handshake at edge T:** awready=1 from T. The next AW can be accepted at T+1. Minimum burst turnaround is 3 cycles for a 1-beat burst.
- **Simultaneous events:** the AW and W channels are not accepted in the same cycle, because wready is 0 in IDLE.

## Test plan
- **Single beat:** awaddr=0x0000_0005, awlen=0, INCR, wdata=0xA5…A5, wstrb=all-ones, wlast=1 → one sram_wen with waddr=5 and that data; bresp=00 one cycle later; awready returns after bready.
- **INCR wrap:** awaddr[9:0]=1022, awlen=3, back-to-back beats D0..D3 → sram_waddr 1022, 1023, 0, 1 on four consecutive cycles; bresp=00.
- **FIXED plus strobes:** awburst=00, awaddr=0x10, awlen=2, wstrb=0x0000000F, 0, 0xFFFFFFFF → three writes all at address 16 with the matching sram_wstrb; bresp=00.
- **wlast mismatch:** awlen=3 with wlast on beat 1, then on no beat → all four beats written; bvalid only after beat 3; bresp=10. The next clean burst returns bresp=00.
- **Back-pressure:** wvalid toggles 1,0,1,0 and bready is held low for 5 cycles → no sram_wen in idle cycles; bvalid and bresp stable for those 5 cycles; awready stays 0 until the B handshake.
- **Reset mid-burst:** rst=1 after beat 1 of an awlen=7 burst → all outputs 0 immediately; no bvalid; awready=1 one edge after release; a new 1-beat burst completes normally.
